// File: rtl/control_unit_pkg.sv
// rtl/control_unit_pkg.sv - shared encodings for the ARM-subset control unit
package control_unit_pkg;

  // Instruction class, Instr[27:26]; 2'b11 is undefined and has no member
  typedef enum logic [1:0] {
    OP_DP  = 2'b00,
    OP_MEM = 2'b01,
    OP_B   = 2'b10
  } op_e;

  // Data-processing command, Funct[4:1]
  typedef enum logic [3:0] {
    CMD_AND = 4'b0000,
    CMD_EOR = 4'b0001,
    CMD_SUB = 4'b0010,
    CMD_ADD = 4'b0100,
    CMD_CMP = 4'b1010,
    CMD_ORR = 4'b1100,
    CMD_MOV = 4'b1101
  } cmd_e;

  // Condition field, Instr[31:28]; 4'b1111 is treated as never
  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110
  } cond_e;

  // ALU operation select driven to the datapath
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_ORR = 3'b011,
    ALU_EOR = 3'b100,
    ALU_MOV = 3'b101
  } alu_e;

  // Architectural flags, bit 3 down to bit 0
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

endpackage

// File: rtl/cond_logic.sv
// rtl/cond_logic.sv - NZCV flag register, condition check and enable gating
module cond_logic
  import control_unit_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] flags,
  input  logic [1:0] flag_w,
  input  logic       pcs,
  input  logic       reg_w,
  input  logic       mem_w,
  input  logic       no_write,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite
);

  nzcv_t flags_q;
  logic  cond_ex;

  // Evaluate the condition field against the stored flags only, so new
  // flags affect the instruction after the one that produced them
  always_comb begin
    cond_ex = 1'b0;
    case (Cond)
      COND_EQ: cond_ex = flags_q.z;
      COND_NE: cond_ex = ~flags_q.z;
      COND_CS: cond_ex = flags_q.c;
      COND_CC: cond_ex = ~flags_q.c;
      COND_MI: cond_ex = flags_q.n;
      COND_PL: cond_ex = ~flags_q.n;
      COND_VS: cond_ex = flags_q.v;
      COND_VC: cond_ex = ~flags_q.v;
      COND_HI: cond_ex = flags_q.c & ~flags_q.z;
      COND_LS: cond_ex = ~flags_q.c | flags_q.z;
      COND_GE: cond_ex = (flags_q.n == flags_q.v);
      COND_LT: cond_ex = (flags_q.n != flags_q.v);
      COND_GT: cond_ex = ~flags_q.z & (flags_q.n == flags_q.v);
      COND_LE: cond_ex = flags_q.z | (flags_q.n != flags_q.v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // Flags update in two independent halves (NZ, CV), only when the
  // instruction actually executes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= '0;
    end else begin
      if (flag_w[1] & cond_ex) flags_q[3:2] <= flags[3:2];
      if (flag_w[0] & cond_ex) flags_q[1:0] <= flags[1:0];
    end
  end

  // Every architectural state change is suppressed by a failed condition
  always_comb begin
    PCSrc    = pcs & cond_ex;
    RegWrite = reg_w & ~no_write & cond_ex;
    MemWrite = mem_w & cond_ex;
  end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - ARM-subset main/ALU decode; CU_SHIFT_EN enables MOV immediate shift
module control_unit
  import control_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  Cond,
  input  logic [1:0]  Op,
  input  logic [5:0]  Funct,
  input  logic [3:0]  Rd,
  input  logic [3:0]  flags,
  input  logic [11:0] Src2,
  output logic        PCSrc,
  output logic        MemtoReg,
  output logic        MemWrite,
  output logic [2:0]  ALUControl,
  output logic        ALUSrc,
  output logic [1:0]  ImmSrc,
  output logic        RegWrite,
  output logic [1:0]  REGSrc,
  output logic        Shift
);

  logic       branch;
  logic       reg_w;
  logic       mem_w;
  logic       alu_op;
  logic       no_write;
  logic [1:0] flag_w;
  logic       pcs;
  logic [3:0] cmd;
  logic       s_bit;
  logic       unused_src2;

  assign cmd         = Funct[4:1];
  assign s_bit       = Funct[0];
  assign unused_src2 = ^Src2;

  // Main decode: instruction class to raw datapath controls
  always_comb begin
    branch   = 1'b0;
    reg_w    = 1'b0;
    mem_w    = 1'b0;
    MemtoReg = 1'b0;
    ALUSrc   = 1'b0;
    ImmSrc   = Op;
    REGSrc   = 2'b00;
    alu_op   = 1'b0;
    case (Op)
      OP_DP: begin
        reg_w  = 1'b1;
        ALUSrc = Funct[5];
        alu_op = 1'b1;
      end
      OP_MEM: begin
        ALUSrc = 1'b1;
        if (Funct[0]) begin
          reg_w    = 1'b1;
          MemtoReg = 1'b1;
        end else begin
          mem_w  = 1'b1;
          REGSrc = 2'b10;
        end
      end
      OP_B: begin
        branch = 1'b1;
        ALUSrc = 1'b1;
        REGSrc = 2'b01;
      end
      default: ;
    endcase
  end

  // ALU decode: only data-processing picks an operation; everything else
  // computes an address with ADD and leaves the flags alone
  always_comb begin
    ALUControl = ALU_ADD;
    no_write   = 1'b0;
    flag_w     = 2'b00;
    if (alu_op) begin
      case (cmd)
        CMD_ADD: begin ALUControl = ALU_ADD; flag_w = {s_bit, s_bit}; end
        CMD_SUB: begin ALUControl = ALU_SUB; flag_w = {s_bit, s_bit}; end
        CMD_AND: begin ALUControl = ALU_AND; flag_w = {s_bit, 1'b0}; end
        CMD_ORR: begin ALUControl = ALU_ORR; flag_w = {s_bit, 1'b0}; end
        CMD_EOR: begin ALUControl = ALU_EOR; flag_w = {s_bit, 1'b0}; end
        CMD_MOV: begin ALUControl = ALU_MOV; flag_w = {s_bit, 1'b0}; end
        CMD_CMP: begin
          ALUControl = ALU_SUB;
          no_write   = 1'b1;
          flag_w     = 2'b11;
        end
        default: begin
          ALUControl = ALU_ADD;
          no_write   = 1'b1;
          flag_w     = {s_bit, 1'b0};
        end
      endcase
    end
  end

  // A write to R15 redirects the PC just like a branch
  assign pcs = branch | ((Rd == 4'hF) & reg_w);

`ifdef CU_SHIFT_EN
  // Route B through the shifter only for MOV with a non-zero immediate shift
  always_comb begin
    Shift = (Op == OP_DP) & ~Funct[5] & (cmd == CMD_MOV) &
            ~Src2[4] & (Src2[11:5] != 7'd0);
  end
`else
  // Without the shifter, MOV of a register is a plain copy
  always_comb begin
    Shift = 1'b0;
  end
`endif

  cond_logic u_cond_logic (
    .clk      (clk),
    .reset    (reset),
    .Cond     (Cond),
    .flags    (flags),
    .flag_w   (flag_w),
    .pcs      (pcs),
    .reg_w    (reg_w),
    .mem_w    (mem_w),
    .no_write (no_write),
    .PCSrc    (PCSrc),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite)
  );

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - randomized model-checked bench for control_unit
module tb_control_unit;

  logic        clk;
  logic        reset;
  logic [3:0]  Cond;
  logic [1:0]  Op;
  logic [5:0]  Funct;
  logic [3:0]  Rd;
  logic [3:0]  flags;
  logic [11:0] Src2;
  logic        PCSrc;
  logic        MemtoReg;
  logic        MemWrite;
  logic [2:0]  ALUControl;
  logic        ALUSrc;
  logic [1:0]  ImmSrc;
  logic        RegWrite;
  logic [1:0]  REGSrc;
  logic        Shift;

  int errs   = 0;
  int checks = 0;

  typedef struct packed {
    logic       pcsrc;
    logic       memtoreg;
    logic       memwrite;
    logic [2:0] aluc;
    logic       alusrc;
    logic [1:0] immsrc;
    logic       regwrite;
    logic [1:0] regsrc;
    logic       shift;
    logic [3:0] next_flags;
  } exp_t;

  logic [3:0] model_flags = 4'b0000;
  logic [3:0] pend_flags  = 4'b0000;

  control_unit dut (
    .clk        (clk),
    .reset      (reset),
    .Cond       (Cond),
    .Op         (Op),
    .Funct      (Funct),
    .Rd         (Rd),
    .flags      (flags),
    .Src2       (Src2),
    .PCSrc      (PCSrc),
    .MemtoReg   (MemtoReg),
    .MemWrite   (MemWrite),
    .ALUControl (ALUControl),
    .ALUSrc     (ALUSrc),
    .ImmSrc     (ImmSrc),
    .RegWrite   (RegWrite),
    .REGSrc     (REGSrc),
    .Shift      (Shift)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ARM condition: pairs of codes share a base test, odd codes invert it
  function automatic logic cond_true(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    if (c == 4'b1111) return 1'b0;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy & ~z;
      3'd5: base = (n == v);
      3'd6: base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return (c == 4'b1110) ? 1'b1 : (base ^ c[0]);
  endfunction

  function automatic exp_t model(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                                 input logic [3:0] r, input logic [3:0] alu_fl,
                                 input logic [11:0] s2, input logic [3:0] stored);
    exp_t e;
    logic ce, dp, ldr, str, br, regw, known, nowrite, fw_nz, fw_cv;
    logic [3:0] cmd;
    e = '0;
    ce  = cond_true(c, stored);
    dp  = (o == 2'd0);
    ldr = (o == 2'd1) && f[0];
    str = (o == 2'd1) && !f[0];
    br  = (o == 2'd2);
    cmd = f[4:1];
    regw = dp || ldr;
    e.memtoreg = ldr;
    e.immsrc   = o;
    e.alusrc   = dp ? f[5] : (o != 2'd3);
    e.regsrc   = str ? 2'b10 : (br ? 2'b01 : 2'b00);
    e.aluc     = 3'd0;
    known      = 1'b1;
    if (dp) begin
      case (cmd)
        4'b0100: e.aluc = 3'd0;
        4'b0010: e.aluc = 3'd1;
        4'b0000: e.aluc = 3'd2;
        4'b1100: e.aluc = 3'd3;
        4'b0001: e.aluc = 3'd4;
        4'b1101: e.aluc = 3'd5;
        4'b1010: e.aluc = 3'd1;
        default: known = 1'b0;
      endcase
    end
    nowrite = dp && (!known || cmd == 4'b1010);
    fw_nz = dp && (f[0] || cmd == 4'b1010);
    fw_cv = dp && ((f[0] && (cmd == 4'b0100 || cmd == 4'b0010)) || cmd == 4'b1010);
    e.pcsrc    = (br || (r == 4'hF && regw)) && ce;
    e.regwrite = regw && !nowrite && ce;
    e.memwrite = str && ce;
`ifdef CU_SHIFT_EN
    e.shift = dp && !f[5] && cmd == 4'b1101 && !s2[4] && (s2[11:5] != 7'd0);
`else
    e.shift = 1'b0 & s2[0];
`endif
    e.next_flags = stored;
    if (fw_nz && ce) e.next_flags[3:2] = alu_fl[3:2];
    if (fw_cv && ce) e.next_flags[1:0] = alu_fl[1:0];
    return e;
  endfunction

  // Check every output against the model once per cycle, then advance the
  // model's flag state at the clock edge
  always begin
    exp_t e;
    logic [3:0] cur;
    @(negedge clk);
    cur = reset ? 4'b0000 : model_flags;
    e = model(Cond, Op, Funct, Rd, flags, Src2, cur);
    chk("PCSrc",      32'(PCSrc),      32'(e.pcsrc));
    chk("MemtoReg",   32'(MemtoReg),   32'(e.memtoreg));
    chk("MemWrite",   32'(MemWrite),   32'(e.memwrite));
    chk("ALUControl", 32'(ALUControl), 32'(e.aluc));
    chk("ALUSrc",     32'(ALUSrc),     32'(e.alusrc));
    chk("ImmSrc",     32'(ImmSrc),     32'(e.immsrc));
    chk("RegWrite",   32'(RegWrite),   32'(e.regwrite));
    chk("REGSrc",     32'(REGSrc),     32'(e.regsrc));
    chk("Shift",      32'(Shift),      32'(e.shift));
    pend_flags = e.next_flags;
    @(posedge clk);
    model_flags = reset ? 4'b0000 : pend_flags;
  end

  task automatic drive(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                       input logic [3:0] r, input logic [3:0] fl, input logic [11:0] s2);
    @(posedge clk);
    #1;
    Cond = c; Op = o; Funct = f; Rd = r; flags = fl; Src2 = s2;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    Cond = 4'b0000; Op = 2'b00; Funct = 6'b000000; Rd = 4'b0000; flags = 4'b0000; Src2 = 12'h000;

    // Reset state: AND reg under EQ with cleared flags does not execute
    settle();
    chk("rst_RegWrite", 32'(RegWrite), 32'd0);
    chk("rst_ALUControl", 32'(ALUControl), 32'd2);
    @(posedge clk); #1; reset = 1'b0;
    settle();
    chk("and_eq_RegWrite", 32'(RegWrite), 32'd0);
    chk("and_eq_PCSrc", 32'(PCSrc), 32'd0);
    chk("and_eq_MemWrite", 32'(MemWrite), 32'd0);
    chk("and_eq_ALUControl", 32'(ALUControl), 32'd2);
    chk("and_eq_ALUSrc", 32'(ALUSrc), 32'd0);

    // STR under GE with zero flags
    drive(4'b1010, 2'b01, 6'b011010, 4'b0010, 4'b1100, 12'hAAA);
    settle();
    chk("str_MemWrite", 32'(MemWrite), 32'd1);
    chk("str_REGSrc", 32'(REGSrc), 32'd2);
    chk("str_ALUSrc", 32'(ALUSrc), 32'd1);
    chk("str_ImmSrc", 32'(ImmSrc), 32'd1);
    chk("str_RegWrite", 32'(RegWrite), 32'd0);
    chk("str_ALUControl", 32'(ALUControl), 32'd0);

    // Flag-setting op, then EQ true / NE false on the next instructions
    drive(4'b1110, 2'b00, 6'b000101, 4'b0001, 4'b0100, 12'h000);
    settle();
    chk("subs_RegWrite", 32'(RegWrite), 32'd1);
    drive(4'b0000, 2'b00, 6'b001000, 4'b0001, 4'b0000, 12'h000);
    settle();
    chk("eq_true_RegWrite", 32'(RegWrite), 32'd1);
    drive(4'b0001, 2'b00, 6'b001000, 4'b0001, 4'b0000, 12'h000);
    settle();
    chk("ne_false_RegWrite", 32'(RegWrite), 32'd0);

    // Branch, then MOV to R15
    drive(4'b1110, 2'b10, 6'b101010, 4'b0000, 4'b0000, 12'h000);
    settle();
    chk("b_PCSrc", 32'(PCSrc), 32'd1);
    chk("b_ImmSrc", 32'(ImmSrc), 32'd2);
    chk("b_REGSrc", 32'(REGSrc), 32'd1);
    chk("b_RegWrite", 32'(RegWrite), 32'd0);
    drive(4'b1110, 2'b00, 6'b011010, 4'b1111, 4'b0000, 12'h000);
    settle();
    chk("movpc_PCSrc", 32'(PCSrc), 32'd1);
    chk("movpc_ALUControl", 32'(ALUControl), 32'd5);

    // CMP writes all flags but no register; GE/LT see N=V=1 next cycle
    drive(4'b1110, 2'b00, 6'b010100, 4'b0011, 4'b1001, 12'h000);
    settle();
    chk("cmp_RegWrite", 32'(RegWrite), 32'd0);
    chk("cmp_ALUControl", 32'(ALUControl), 32'd1);
    drive(4'b1010, 2'b00, 6'b001000, 4'b0011, 4'b0000, 12'h000);
    settle();
    chk("ge_true_RegWrite", 32'(RegWrite), 32'd1);
    drive(4'b1011, 2'b00, 6'b001000, 4'b0011, 4'b0000, 12'h000);
    settle();
    chk("lt_false_RegWrite", 32'(RegWrite), 32'd0);

    // Undefined Op
    drive(4'b1110, 2'b11, 6'b111111, 4'b1111, 4'b0000, 12'hFFF);
    settle();
    chk("undef_ImmSrc", 32'(ImmSrc), 32'd3);
    chk("undef_enables", 32'({PCSrc, RegWrite, MemWrite, MemtoReg, ALUSrc}), 32'd0);

    // Mid-cycle asynchronous reset drops EQ-qualified enables at once
    drive(4'b1110, 2'b00, 6'b000101, 4'b0001, 4'b0100, 12'h000);
    drive(4'b0000, 2'b00, 6'b011010, 4'b1111, 4'b0000, 12'h000);
    settle();
    chk("pre_rst_PCSrc", 32'(PCSrc), 32'd1);
    chk("pre_rst_RegWrite", 32'(RegWrite), 32'd1);
    reset = 1'b1;
    #1;
    chk("async_rst_PCSrc", 32'(PCSrc), 32'd0);
    chk("async_rst_RegWrite", 32'(RegWrite), 32'd0);
    @(posedge clk); #1; reset = 1'b0;
    drive(4'b0001, 2'b00, 6'b001000, 4'b0001, 4'b0000, 12'h000);
    settle();
    chk("post_rst_ne_RegWrite", 32'(RegWrite), 32'd1);

    // Randomized traffic with occasional asynchronous resets
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      reset = ($urandom_range(0, 63) == 0);
      Cond  = ($urandom_range(0, 3) == 0) ? 4'b1110 : 4'($urandom);
      Op    = 2'($urandom);
      Funct = 6'($urandom);
      Rd    = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
      flags = 4'($urandom);
      Src2  = 12'($urandom);
    end
    @(posedge clk); #1; reset = 1'b0;
    settle();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
